// File: rtl/uart_cfg_pkg.sv
// Shared types and constants for the UART configuration frame controller.
package uart_cfg_pkg;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_CMD  = 3'd1,
        S_DATA = 3'd2,
        S_CHK  = 3'd3,
        S_EXEC = 3'd4,
        S_RESP = 3'd5
    } state_t;

    typedef enum logic [1:0] {
        ERR_NONE    = 2'b00,
        ERR_CHK     = 2'b01,
        ERR_ADDR    = 2'b10,
        ERR_TIMEOUT = 2'b11
    } err_code_t;

    localparam logic [7:0] SOF_BYTE = 8'hA5;
    localparam logic [7:0] ACK_BYTE = 8'h06;
    localparam logic [7:0] NAK_BYTE = 8'h15;

    function automatic logic frame_chk_ok(input logic [7:0] cmd,
                                          input logic [7:0] data,
                                          input logic [7:0] chk);
        return (cmd ^ data) == chk;
    endfunction

endpackage

// File: rtl/uart_cfg_regbank.sv
// Bank of 8-bit configuration registers with one write port.
// The read port exists only when UART_CFG_READBACK_EN is defined.
module uart_cfg_regbank
    import uart_cfg_pkg::*;
#(
    parameter int         NUM_REGS  = 16,
    parameter logic [7:0] RESET_VAL = 8'h00
) (
    input  logic                  i_Clock,
    input  logic                  i_Reset,
    input  logic                  wr_en,
    input  logic [3:0]            wr_addr,
    input  logic [7:0]            wr_data,
`ifdef UART_CFG_READBACK_EN
    input  logic [3:0]            rd_addr,
    output logic [7:0]            rd_data,
`endif
    output logic [8*NUM_REGS-1:0] regs
);

    always_ff @(posedge i_Clock or posedge i_Reset) begin
        if (i_Reset) begin
            regs <= {NUM_REGS{RESET_VAL}};
        end else if (wr_en) begin
            for (int k = 0; k < NUM_REGS; k++) begin
                if (wr_addr == 4'(k)) regs[8*k +: 8] <= wr_data;
            end
        end
    end

`ifdef UART_CFG_READBACK_EN
    always_comb begin
        rd_data = 8'h00;
        for (int k = 0; k < NUM_REGS; k++) begin
            if (rd_addr == 4'(k)) rd_data = regs[8*k +: 8];
        end
    end
`endif

endmodule

// File: rtl/uart_cfg_ctrl.sv
// Frame controller: parses A5/CMD/DATA/CHK frames from the UART receiver, updates the
// register bank and returns a one-byte response. Readback gated by UART_CFG_READBACK_EN.
//
//  state  | meaning
//  S_IDLE | waiting for SOF byte, other bytes dropped
//  S_CMD  | waiting for command byte
//  S_DATA | waiting for data byte
//  S_CHK  | waiting for checksum byte
//  S_EXEC | one cycle: validate frame, write register, pick response
//  S_RESP | response launched, waiting for transmitter done
module uart_cfg_ctrl
    import uart_cfg_pkg::*;
#(
    parameter int         NUM_REGS     = 16,
    parameter int         TIMEOUT_CLKS = 57280,
    parameter logic [7:0] RESET_VAL    = 8'h00
) (
    input  logic                  i_Clock,
    input  logic                  i_Reset,
    input  logic                  i_Rx_DV,
    input  logic [7:0]            i_Rx_Byte,
    output logic                  o_Tx_DV,
    output logic [7:0]            o_Tx_Byte,
    input  logic                  i_Tx_Done,
    output logic [8*NUM_REGS-1:0] o_Cfg_Regs,
    output logic                  o_Wr_Strobe,
    output logic [3:0]            o_Wr_Addr,
    output logic                  o_Err,
    output logic [1:0]            o_Err_Code,
    output logic                  o_Busy
);

    localparam int              CNT_W      = $clog2(TIMEOUT_CLKS);
    localparam logic [CNT_W-1:0] TMO_LAST  = CNT_W'(TIMEOUT_CLKS - 1);
    localparam logic [4:0]      NUM_REGS_W = 5'(NUM_REGS);

    state_t           state;
    logic [7:0]       cmd_q;
    logic [7:0]       data_q;
    logic [7:0]       chk_q;
    logic [CNT_W-1:0] tmo_cnt;
    logic             in_frame;
    logic             tmo_expire;
    logic             chk_bad;
    logic             addr_bad;
    logic             do_write;

    assign in_frame   = (state == S_CMD) || (state == S_DATA) || (state == S_CHK);
    // A byte arriving on the expiry cycle takes priority over the abort.
    assign tmo_expire = in_frame && !i_Rx_DV && (tmo_cnt == TMO_LAST);
    assign chk_bad    = !frame_chk_ok(cmd_q, data_q, chk_q);
`ifdef UART_CFG_READBACK_EN
    assign addr_bad   = ({1'b0, cmd_q[3:0]} >= NUM_REGS_W) || (cmd_q[6:4] != 3'b000);
`else
    assign addr_bad   = ({1'b0, cmd_q[3:0]} >= NUM_REGS_W) || (cmd_q[6:4] != 3'b000) || !cmd_q[7];
`endif
    assign do_write   = (state == S_EXEC) && !chk_bad && !addr_bad && cmd_q[7];
    assign o_Busy     = (state != S_IDLE);

`ifdef UART_CFG_READBACK_EN
    logic [7:0] rd_data;
`endif

    uart_cfg_regbank #(
        .NUM_REGS  (NUM_REGS),
        .RESET_VAL (RESET_VAL)
    ) u_regbank (
        .i_Clock (i_Clock),
        .i_Reset (i_Reset),
        .wr_en   (do_write),
        .wr_addr (cmd_q[3:0]),
        .wr_data (data_q),
`ifdef UART_CFG_READBACK_EN
        .rd_addr (cmd_q[3:0]),
        .rd_data (rd_data),
`endif
        .regs    (o_Cfg_Regs)
    );

    always_ff @(posedge i_Clock or posedge i_Reset) begin
        if (i_Reset) begin
            state       <= S_IDLE;
            cmd_q       <= 8'h00;
            data_q      <= 8'h00;
            chk_q       <= 8'h00;
            tmo_cnt     <= '0;
            o_Tx_DV     <= 1'b0;
            o_Tx_Byte   <= 8'h00;
            o_Wr_Strobe <= 1'b0;
            o_Wr_Addr   <= 4'h0;
            o_Err       <= 1'b0;
            o_Err_Code  <= ERR_NONE;
        end else begin
            o_Tx_DV     <= 1'b0;
            o_Wr_Strobe <= 1'b0;
            o_Err       <= 1'b0;

            if (i_Rx_DV || !in_frame) tmo_cnt <= '0;
            else if (!tmo_expire)     tmo_cnt <= tmo_cnt + CNT_W'(1);

            case (state)
                S_IDLE: if (i_Rx_DV && (i_Rx_Byte == SOF_BYTE)) state <= S_CMD;
                S_CMD: if (i_Rx_DV) begin
                    cmd_q <= i_Rx_Byte;
                    state <= S_DATA;
                end
                S_DATA: if (i_Rx_DV) begin
                    data_q <= i_Rx_Byte;
                    state  <= S_CHK;
                end
                S_CHK: if (i_Rx_DV) begin
                    chk_q <= i_Rx_Byte;
                    state <= S_EXEC;
                end
                S_EXEC: begin
                    state   <= S_RESP;
                    o_Tx_DV <= 1'b1;
                    if (chk_bad) begin
                        o_Err      <= 1'b1;
                        o_Err_Code <= ERR_CHK;
                        o_Tx_Byte  <= NAK_BYTE;
                    end else if (addr_bad) begin
                        o_Err      <= 1'b1;
                        o_Err_Code <= ERR_ADDR;
                        o_Tx_Byte  <= NAK_BYTE;
                    end else if (cmd_q[7]) begin
                        o_Wr_Strobe <= 1'b1;
                        o_Wr_Addr   <= cmd_q[3:0];
                        o_Tx_Byte   <= ACK_BYTE;
`ifdef UART_CFG_READBACK_EN
                    end else begin
                        o_Tx_Byte <= rd_data;
`endif
                    end
                end
                S_RESP: if (i_Tx_Done) state <= S_IDLE;
                default: state <= S_IDLE;
            endcase

            if (tmo_expire) begin
                state      <= S_IDLE;
                o_Err      <= 1'b1;
                o_Err_Code <= ERR_TIMEOUT;
            end
        end
    end

endmodule
